// File: rtl/sync_fifo_reader_if.sv
// Bundle for sync_fifo_reader: the FIFO read port it pops from and the
// valid/ready stream it produces.
//
// Stream handshake: a word moves on a rising edge where m_valid_o and
// m_ready_i are both high. Once m_valid_o is high, m_valid_o and m_data_o
// stay unchanged until that edge. m_valid_o never depends on m_ready_i.
interface sync_fifo_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  fifo_empty_i;
  logic [DATA_WIDTH-1:0] fifo_rd_data_i;
  logic                  fifo_read_o;
  logic                  m_valid_o;
  logic [DATA_WIDTH-1:0] m_data_o;
  logic                  m_ready_i;

  modport master (
    input  fifo_empty_i,
    input  fifo_rd_data_i,
    input  m_ready_i,
    output fifo_read_o,
    output m_valid_o,
    output m_data_o
  );

  modport slave (
    output fifo_empty_i,
    output fifo_rd_data_i,
    output m_ready_i,
    input  fifo_read_o,
    input  m_valid_o,
    input  m_data_o
  );
endinterface

// File: rtl/sync_fifo_reader.sv
// Pops a synchronous FIFO (FWFT or registered read data) into a 3-entry
// skid buffer and presents the words as a valid/ready stream.
module sync_fifo_reader #(
  parameter int DATA_WIDTH = 32,
  parameter bit FWFT       = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic                     flush_i,
  sync_fifo_reader_if.master       bus,
  output logic [15:0]              word_count_o,
  output logic                     idle_o
);

  localparam logic [1:0] DEPTH = 2'd3;

  logic [1:0]            occ_q, occ_d;
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic                  infl_q, infl_d;
  logic [15:0]           wcnt_q, wcnt_d;
  logic [DATA_WIDTH-1:0] buf_q [3];
  logic [DATA_WIDTH-1:0] buf_d [3];

  logic                  pop;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  m_valid;
  logic                  hs;
  logic [2:0]            fill;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Buffered plus in-flight words bound the pops, so a pop can never outrun
  // the free space even when the consumer stalls for ever.
  assign fill = {1'b0, occ_q} + {2'b00, infl_q};
  assign pop  = enable_i & ~bus.fifo_empty_i & ~flush_i & ~rst_i & (fill < {1'b0, DEPTH});

  generate
    if (FWFT) begin : g_fwft
      // Read data is already valid alongside the pop.
      always_comb begin
        wr_en   = pop;
        wr_data = bus.fifo_rd_data_i;
        infl_d  = 1'b0;
      end
    end else begin : g_reg
      // Read data appears the cycle after the pop; infl_q marks that cycle.
      always_comb begin
        wr_en   = infl_q & ~flush_i;
        wr_data = bus.fifo_rd_data_i;
        infl_d  = pop;
      end
    end
  endgenerate

  assign m_valid = (occ_q != 2'd0) & ~rst_i;
  assign hs      = m_valid & bus.m_ready_i;

  always_comb begin
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wcnt_d   = wcnt_q + {15'd0, hs};
    for (int i = 0; i < 3; i++) begin
      buf_d[i] = buf_q[i];
    end

    if (flush_i) begin
      occ_d    = 2'd0;
      wr_ptr_d = 2'd0;
      rd_ptr_d = 2'd0;
    end else begin
      if (wr_en) begin
        buf_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (hs) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end
      occ_d = occ_q + {1'b0, wr_en} - {1'b0, hs};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q    <= 2'd0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      infl_q   <= 1'b0;
      wcnt_q   <= 16'd0;
      for (int i = 0; i < 3; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      infl_q   <= infl_d;
      wcnt_q   <= wcnt_d;
      for (int i = 0; i < 3; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  assign bus.fifo_read_o = pop;
  assign bus.m_valid_o   = m_valid;
  assign bus.m_data_o    = buf_q[rd_ptr_q];
  assign word_count_o    = wcnt_q;
  assign idle_o          = (occ_q == 2'd0) & ~infl_q & ~pop;

  // A write into a full buffer would silently overwrite the head word.
  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
    !(wr_en && (occ_q == DEPTH)));

endmodule

// File: doc/sync_fifo_reader.md
SYNC_FIFO_READER -- requirements
Module: sync_fifo_reader

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of the FIFO word and the output stream data.
REQ-002 Parameter: FWFT, default 1; 1 = FIFO read data valid while fifo_empty_i low, 0 = FIFO read data registered and valid one cycle after the pop.
REQ-003 clk_i  in  1  single clock; all logic on its rising edge.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 enable_i  in  1  permits issuing new FIFO pops.
REQ-006 flush_i  in  1  synchronous discard of all buffered and in-flight words.
REQ-007 fifo_empty_i  in  1  FIFO registered empty flag.
REQ-008 fifo_rd_data_i  in  DATA_WIDTH  FIFO read port data.
REQ-009 fifo_read_o  out  1  FIFO pop request.
REQ-010 m_valid_o  out  1  output stream word valid.
REQ-011 m_data_o  out  DATA_WIDTH  output stream word.
REQ-012 m_ready_i  in  1  output stream consumer ready.
REQ-013 word_count_o  out  16  count of completed output handshakes.
REQ-014 idle_o  out  1  no buffered word, no in-flight pop, no pop being issued.

Function
REQ-015 Internal 3-entry circular output buffer: read/write pointers wrap 2->0, occupancy counter occ 0..3.
REQ-016 In-flight flag infl (FWFT=0 only): set the cycle after a pop, marks data arriving on fifo_rd_data_i; always 0 when FWFT=1.
REQ-017 fifo_read_o = enable_i & !fifo_empty_i & !flush_i & !rst_i & (occ + infl < 3); computed from registered state only, no combinational path from m_ready_i.
REQ-018 FWFT=1: on a pop, fifo_rd_data_i is written into the buffer at the same edge.
REQ-019 FWFT=0: fifo_rd_data_i is written into the buffer at the edge following the pop (infl=1 cycle).
REQ-020 Handshake: a transfer occurs on an edge where m_valid_o & m_ready_i; buffer head then advances.
REQ-021 m_valid_o = (occ != 0); m_data_o = buffer head entry.
REQ-022 While m_valid_o=1 and m_ready_i=0, m_data_o is held stable and m_valid_o stays 1.
REQ-023 Simultaneous write-in and handshake: occ is unchanged, both pointers advance.
REQ-024 Latency from pop to m_valid_o: 1 cycle for FWFT=1, 2 cycles for FWFT=0.
REQ-025 Throughput: one word per cycle sustained in both modes when m_ready_i=1 and the FIFO is non-empty.
REQ-026 Words leave in exactly the FIFO pop order; no word is duplicated or dropped except by flush_i.
REQ-027 Buffer overflow never occurs (guaranteed by REQ-017); write with occ=3 is a design error flagged by an assertion.
REQ-028 enable_i low: no new pops; buffered and in-flight words are still delivered.
REQ-029 flush_i high: occ, pointers and infl cleared next edge; m_valid_o=0 next cycle.
REQ-030 If flush_i is high while infl=1, the arriving word is discarded.
REQ-031 If flush_i is high in the cycle after a pop issued with FWFT=0, the word arriving that cycle is discarded.
REQ-032 word_count_o increments by 1 per handshake and wraps 0xFFFF->0x0000; flush_i does not clear it.
REQ-033 idle_o = (occ==0) & !infl & !fifo_read_o.

Reset
REQ-034 rst_i high at an edge: occ=0, pointers=0, infl=0, word_count_o=0, m_data_o=0.
REQ-035 During rst_i high, fifo_read_o=0 and m_valid_o=0.
REQ-036 Reset mid-operation discards all buffered and in-flight words; first pop is allowed the cycle after rst_i falls.

Verification
REQ-037 FWFT=1, FIFO holds 0xA0..0xA3, m_ready_i=1, enable_i=1 -> fifo_read_o high cycles 0-3, m_valid_o high cycles 1-4, data 0xA0..0xA3 in order, word_count_o=4.
REQ-038 FWFT=0, 8 words queued, m_ready_i=1 -> fifo_read_o high 8 consecutive cycles, m_valid_o high 8 consecutive cycles starting 2 cycles after the first pop.
REQ-039 FWFT=0, m_ready_i=0 -> exactly 3 pops, then fifo_read_o=0, m_valid_o=1 with m_data_o=0xA0 held; m_ready_i=1 -> 0xA0,0xA1,0xA2,... delivered without gap or loss.
REQ-040 FWFT=0, flush_i asserted the cycle after popping 0xB1 with 0xB0 buffered -> m_valid_o=0 next cycle, 0xB0 and 0xB1 never appear, the next delivered word is 0xB2.
REQ-041 rst_i pulsed with occ=2 -> next cycle m_valid_o=0, word_count_o=0, fifo_read_o=0 during reset, pops resume the cycle after release.
REQ-042 Preload word_count_o=0xFFFF via 65535 handshakes, then one more handshake -> word_count_o=0x0000.
